// File: rtl/sdram_pkg.sv
// Shared types and address decode for the SDRAM host command front end.
package sdram_pkg;

   localparam int ROW_BITS  = 13;
   localparam int COL_BITS  = 9;
   localparam int BANK_BITS = 2;
   localparam int DATA_BITS = 16;
   localparam int ADDR_BITS = ROW_BITS + BANK_BITS + COL_BITS;

   typedef struct packed {
      logic                 write;
      logic [BANK_BITS-1:0] bank;
      logic [ROW_BITS-1:0]  row;
      logic [COL_BITS-1:0]  col;
      logic [DATA_BITS-1:0] wdata;
   } cmd_t;

   // Host word address is laid out as {row, bank, col}.
   function automatic cmd_t make_cmd(input logic                 write,
                                     input logic [ADDR_BITS-1:0] addr,
                                     input logic [DATA_BITS-1:0] wdata);
      cmd_t c;
      c.write = write;
      c.col   = addr[COL_BITS-1:0];
      c.bank  = addr[COL_BITS +: BANK_BITS];
      c.row   = addr[COL_BITS+BANK_BITS +: ROW_BITS];
      c.wdata = wdata;
      return c;
   endfunction

endpackage

// File: rtl/sdram_open_row_table.sv
// Per-bank open-row tracker with set/clear/init-clear and a bank+row lookup.
module sdram_open_row_table #(
   parameter int BANK_BITS = 2,
   parameter int ROW_BITS  = 13
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_init,
   input  logic                 set_pulse,
   input  logic [BANK_BITS-1:0] set_bank,
   input  logic [ROW_BITS-1:0]  set_row,
   input  logic                 clear_pulse,
   input  logic [BANK_BITS-1:0] clear_bank,
   input  logic [BANK_BITS-1:0] lookup_bank,
   input  logic [ROW_BITS-1:0]  lookup_row,
   output logic                 hit
);

   localparam int NB = 1 << BANK_BITS;

   logic [NB-1:0]       open_v;
   logic [ROW_BITS-1:0] open_row [NB];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         open_v <= '0;
         // NOTE: the row array is small and must read as zero after reset, so it is reset like any flop.
         for (int i = 0; i < NB; i++) open_row[i] <= '0;
      end else if (in_init) begin
         open_v <= '0;
      end else begin
         // NOTE: later non-blocking assignment to the same bit wins, which makes set beat clear on one bank.
         if (clear_pulse) open_v[clear_bank] <= 1'b0;
         if (set_pulse) begin
            open_v[set_bank]   <= 1'b1;
            open_row[set_bank] <= set_row;
         end
      end
   end

   assign hit = open_v[lookup_bank] && (open_row[lookup_bank] == lookup_row);

endmodule

// File: rtl/sdram_cmd_pipe.sv
// Host request front end: decode into stage R, hand over to stage Q, open-row hit.
// Macro SDRAM_ROW_HIT_EN builds the open-row table; without it row_hit is tied 0.
module sdram_cmd_pipe #(
   parameter int ROW_BITS  = sdram_pkg::ROW_BITS,
   parameter int COL_BITS  = sdram_pkg::COL_BITS,
   parameter int BANK_BITS = sdram_pkg::BANK_BITS,
   parameter int DATA_BITS = sdram_pkg::DATA_BITS,
   parameter int ADDR_BITS = ROW_BITS + BANK_BITS + COL_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 host_valid,
   output logic                 host_ready,
   input  logic                 host_write,
   input  logic [ADDR_BITS-1:0] host_addr,
   input  logic [DATA_BITS-1:0] host_wdata,
   input  logic                 in_init,
   input  logic                 accept_q_pulse,
   input  logic                 set_active_pulse,
   input  logic [BANK_BITS-1:0] set_bank,
   input  logic [ROW_BITS-1:0]  set_row,
   input  logic                 clear_active_pulse,
   input  logic [BANK_BITS-1:0] clear_bank,
   output logic                 cmd_valid_r,
   output logic                 cmd_write_r,
   output logic [BANK_BITS-1:0] new_bank,
   output logic [COL_BITS-1:0]  new_col,
   output logic [ROW_BITS-1:0]  new_row,
   output logic                 cmd_write_q,
   output logic [BANK_BITS-1:0] cur_bank,
   output logic [COL_BITS-1:0]  cur_col,
   output logic [ROW_BITS-1:0]  cur_row,
   output logic [DATA_BITS-1:0] cur_wdata,
   output logic                 row_hit
);

   import sdram_pkg::*;

   cmd_t r_q;
   cmd_t q_q;
   logic r_valid;
   logic host_fire;

   assign host_ready = !in_init && (!r_valid || accept_q_pulse);
   assign host_fire  = host_valid && host_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_q     <= '0;
         q_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments let Q capture the old R while R reloads on the same edge.
         if (accept_q_pulse && r_valid) q_q <= r_q;
         if (host_fire) begin
            r_q     <= make_cmd(host_write, host_addr, host_wdata);
            r_valid <= 1'b1;
         end else if (accept_q_pulse) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign cmd_valid_r = r_valid;
   assign cmd_write_r = r_q.write;
   assign new_bank    = r_q.bank;
   assign new_col     = r_q.col;
   assign new_row     = r_q.row;
   assign cmd_write_q = q_q.write;
   assign cur_bank    = q_q.bank;
   assign cur_col     = q_q.col;
   assign cur_row     = q_q.row;
   assign cur_wdata   = q_q.wdata;

`ifdef SDRAM_ROW_HIT_EN
   logic table_hit;

   sdram_open_row_table #(
      .BANK_BITS (BANK_BITS),
      .ROW_BITS  (ROW_BITS)
   ) u_open_row_table (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_init     (in_init),
      .set_pulse   (set_active_pulse),
      .set_bank    (set_bank),
      .set_row     (set_row),
      .clear_pulse (clear_active_pulse),
      .clear_bank  (clear_bank),
      .lookup_bank (r_q.bank),
      .lookup_row  (r_q.row),
      .hit         (table_hit)
   );

   assign row_hit = r_valid && table_hit;
`else
   // Closed-page build: table controls are accepted but have no effect.
   logic unused_table_ctrl;
   assign unused_table_ctrl = ^{set_active_pulse, set_bank, set_row, clear_active_pulse, clear_bank};
   assign row_hit = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_cmd_pipe.sv
// Self-checking bench for sdram_cmd_pipe against an arithmetic reference model.
// Expected row_hit follows SDRAM_ROW_HIT_EN exactly as the design build does.
module tb_sdram_cmd_pipe;

`ifdef SDRAM_ROW_HIT_EN
   localparam bit HIT_EN = 1'b1;
`else
   localparam bit HIT_EN = 1'b0;
`endif

   logic        clk, rst_n;
   logic        host_valid, host_ready, host_write;
   logic [23:0] host_addr;
   logic [15:0] host_wdata;
   logic        in_init, accept_q_pulse;
   logic        set_active_pulse, clear_active_pulse;
   logic [1:0]  set_bank, clear_bank;
   logic [12:0] set_row;
   logic        cmd_valid_r, cmd_write_r, cmd_write_q, row_hit;
   logic [1:0]  new_bank, cur_bank;
   logic [8:0]  new_col, cur_col;
   logic [12:0] new_row, cur_row;
   logic [15:0] cur_wdata;

   int tests_run = 0;
   int tests_failed = 0;

   sdram_cmd_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .host_valid(host_valid), .host_ready(host_ready), .host_write(host_write),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .in_init(in_init), .accept_q_pulse(accept_q_pulse),
      .set_active_pulse(set_active_pulse), .set_bank(set_bank), .set_row(set_row),
      .clear_active_pulse(clear_active_pulse), .clear_bank(clear_bank),
      .cmd_valid_r(cmd_valid_r), .cmd_write_r(cmd_write_r),
      .new_bank(new_bank), .new_col(new_col), .new_row(new_row),
      .cmd_write_q(cmd_write_q), .cur_bank(cur_bank), .cur_col(cur_col),
      .cur_row(cur_row), .cur_wdata(cur_wdata), .row_hit(row_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: request records and the open-row table as plain integers.
   bit m_rv, m_rw, m_qw;
   int m_rbank, m_rrow, m_rcol, m_rdata;
   int m_qbank, m_qrow, m_qcol, m_qdata;
   bit m_ov [4];
   int m_orow [4];

   task automatic model_reset();
      m_rv = 0; m_rw = 0; m_qw = 0;
      m_rbank = 0; m_rrow = 0; m_rcol = 0; m_rdata = 0;
      m_qbank = 0; m_qrow = 0; m_qcol = 0; m_qdata = 0;
      foreach (m_ov[i]) begin m_ov[i] = 0; m_orow[i] = 0; end
   endtask

   function automatic bit exp_ready();
      return !in_init && (!m_rv || accept_q_pulse);
   endfunction

   function automatic bit exp_hit();
      return HIT_EN && m_rv && m_ov[m_rbank] && (m_orow[m_rbank] == m_rrow);
   endfunction

   function automatic logic [23:0] mk_addr(input int row, input int bank, input int col);
      return 24'(row * 2048 + bank * 512 + col);
   endfunction

   task automatic idle_inputs();
      host_valid = 0; host_write = 0; host_addr = '0; host_wdata = '0;
      in_init = 0; accept_q_pulse = 0;
      set_active_pulse = 0; set_bank = '0; set_row = '0;
      clear_active_pulse = 0; clear_bank = '0;
   endtask

   // Advance model by one edge using currently driven inputs, then step the DUT.
   task automatic tick();
      bit fire;
      fire = host_valid && exp_ready();
      if (accept_q_pulse && m_rv) begin
         m_qw = m_rw; m_qbank = m_rbank; m_qrow = m_rrow; m_qcol = m_rcol; m_qdata = m_rdata;
      end
      if (fire) begin
         m_rv = 1; m_rw = host_write;
         m_rcol = int'(host_addr) % 512;
         m_rbank = (int'(host_addr) / 512) % 4;
         m_rrow = int'(host_addr) / 2048;
         m_rdata = int'(host_wdata);
      end else if (accept_q_pulse) begin
         m_rv = 0;
      end
      if (in_init) begin
         foreach (m_ov[i]) m_ov[i] = 0;
      end else begin
         if (clear_active_pulse) m_ov[clear_bank] = 0;
         if (set_active_pulse) begin m_ov[set_bank] = 1; m_orow[set_bank] = int'(set_row); end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle_inputs();
      accept_q_pulse = 1;
      tick();
      accept_q_pulse = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      model_reset();
      #1;
      tests_run++; if (cmd_valid_r !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", cmd_valid_r); end
      tests_run++; if (row_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_hit got %0b want 0", row_hit); end
      tests_run++; if ({new_row, cur_row, cur_wdata} !== '0) begin tests_failed++; $display("FAIL reset_fields got %h want 0", {new_row, cur_row, cur_wdata}); end
      tests_run++; if (host_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %0b want 1", host_ready); end
      #10 rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_decode();
      host_valid = 1; host_write = 1; host_addr = 24'h123456; host_wdata = 16'hBEEF;
      #1;
      tests_run++; if (host_ready !== 1'b1) begin tests_failed++; $display("FAIL decode_ready_pre got %0b want 1", host_ready); end
      tick();
      host_valid = 0;
      #1;
      tests_run++; if (cmd_valid_r !== 1'b1) begin tests_failed++; $display("FAIL decode_valid got %0b want 1", cmd_valid_r); end
      tests_run++; if (new_row !== 13'h246) begin tests_failed++; $display("FAIL decode_row got %h want 246", new_row); end
      tests_run++; if (new_bank !== 2'd2) begin tests_failed++; $display("FAIL decode_bank got %0d want 2", new_bank); end
      tests_run++; if (new_col !== 9'h056) begin tests_failed++; $display("FAIL decode_col got %h want 056", new_col); end
      tests_run++; if (cmd_write_r !== 1'b1) begin tests_failed++; $display("FAIL decode_write got %0b want 1", cmd_write_r); end
      tests_run++; if (host_ready !== 1'b0) begin tests_failed++; $display("FAIL decode_ready_full got %0b want 0", host_ready); end
      // A held request while R is full must not overwrite R.
      host_valid = 1; host_addr = 24'h000001;
      tick();
      host_valid = 0;
      tests_run++; if (new_col !== 9'h056) begin tests_failed++; $display("FAIL decode_hold got %h want 056", new_col); end
      accept_q_pulse = 1;
      tick();
      accept_q_pulse = 0;
      tests_run++; if (cmd_valid_r !== 1'b0) begin tests_failed++; $display("FAIL accept_clears got %0b want 0", cmd_valid_r); end
      tests_run++; if ({cmd_write_q, cur_row, cur_wdata} !== {1'b1, 13'h246, 16'hBEEF}) begin
         tests_failed++; $display("FAIL accept_q got %h want %h", {cmd_write_q, cur_row, cur_wdata}, {1'b1, 13'h246, 16'hBEEF}); end
      // Accept with R empty must leave Q untouched.
      accept_q_pulse = 1;
      tick();
      accept_q_pulse = 0;
      tests_run++; if (cur_col !== 9'h056) begin tests_failed++; $display("FAIL accept_empty got %h want 056", cur_col); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] addrs [3];
      accept_q_pulse = 1;
      for (int i = 0; i < 3; i++) begin
         addrs[i] = 24'($urandom);
         host_valid = 1; host_write = 1'($urandom); host_addr = addrs[i]; host_wdata = 16'($urandom);
         #1;
         tests_run++; if (host_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready[%0d] got %0b want 1", i, host_ready); end
         tick();
         tests_run++; if ({cmd_valid_r, new_row, new_bank, new_col} !== {1'b1, 13'(addrs[i] / 2048), 2'((addrs[i] / 512) % 4), 9'(addrs[i] % 512)}) begin
            tests_failed++; $display("FAIL b2b_r[%0d] got %h want addr %h", i, {cmd_valid_r, new_row, new_bank, new_col}, addrs[i]); end
         if (i > 0) begin
            tests_run++; if ({cur_row, cur_bank, cur_col} !== addrs[i-1][23:0]) begin
               tests_failed++; $display("FAIL b2b_q[%0d] got %h want %h", i, {cur_row, cur_bank, cur_col}, addrs[i-1]); end
         end
      end
      host_valid = 0;
      tick();
      accept_q_pulse = 0;
      tests_run++; if ({cmd_valid_r, cur_row, cur_bank, cur_col} !== {1'b0, addrs[2]}) begin
         tests_failed++; $display("FAIL b2b_last got %h want %h", {cmd_valid_r, cur_row, cur_bank, cur_col}, {1'b0, addrs[2]}); end
   endtask

   task automatic test_row_hit();
      set_active_pulse = 1; set_bank = 2; set_row = 13'h246;
      tick();
      set_active_pulse = 0;
      host_valid = 1; host_write = 0; host_addr = 24'h123400;
      tick();
      host_valid = 0;
      tests_run++; if (row_hit !== HIT_EN) begin tests_failed++; $display("FAIL hit_same_row got %0b want %0b", row_hit, HIT_EN); end
      accept_q_pulse = 1; host_valid = 1; host_addr = 24'h1A3400;
      tick();
      accept_q_pulse = 0; host_valid = 0;
      tests_run++; if ({new_row, row_hit} !== {13'h346, 1'b0}) begin
         tests_failed++; $display("FAIL hit_other_row got %h want %h", {new_row, row_hit}, {13'h346, 1'b0}); end
      drain();
   endtask

   task automatic test_collision();
      logic [12:0] r;
      r = 13'h0A5;
      set_active_pulse = 1; set_bank = 1; set_row = r;
      clear_active_pulse = 1; clear_bank = 1;
      host_valid = 1; host_addr = mk_addr(int'(r), 1, 3);
      tick();
      idle_inputs();
      tests_run++; if (row_hit !== HIT_EN) begin tests_failed++; $display("FAIL collide_set_wins got %0b want %0b", row_hit, HIT_EN); end
      clear_active_pulse = 1; clear_bank = 1; accept_q_pulse = 1;
      tick();
      idle_inputs();
      host_valid = 1; host_addr = mk_addr(int'(r), 1, 3);
      tick();
      idle_inputs();
      tests_run++; if ({cmd_valid_r, row_hit} !== 2'b10) begin tests_failed++; $display("FAIL collide_cleared got %b want 10", {cmd_valid_r, row_hit}); end
      drain();
   endtask

   task automatic test_init();
      set_active_pulse = 1; set_bank = 0; set_row = 13'h011;
      tick();
      idle_inputs();
      in_init = 1; host_valid = 1; host_addr = mk_addr(17, 0, 9);
      #1;
      tests_run++; if (host_ready !== 1'b0) begin tests_failed++; $display("FAIL init_ready got %0b want 0", host_ready); end
      tick();
      tests_run++; if (cmd_valid_r !== 1'b0) begin tests_failed++; $display("FAIL init_blocked got %0b want 0", cmd_valid_r); end
      in_init = 0;
      #1;
      tests_run++; if (host_ready !== 1'b1) begin tests_failed++; $display("FAIL init_release_ready got %0b want 1", host_ready); end
      tick();
      host_valid = 0;
      tests_run++; if ({cmd_valid_r, new_row, row_hit} !== {1'b1, 13'h011, 1'b0}) begin
         tests_failed++; $display("FAIL init_taken got %h want %h", {cmd_valid_r, new_row, row_hit}, {1'b1, 13'h011, 1'b0}); end
      drain();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         host_valid = 1'($urandom_range(0, 1));
         host_write = 1'($urandom);
         host_addr = mk_addr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 511));
         host_wdata = 16'($urandom);
         in_init = ($urandom_range(0, 15) == 0);
         accept_q_pulse = 1'($urandom_range(0, 1));
         set_active_pulse = ($urandom_range(0, 3) == 0);
         set_bank = 2'($urandom); set_row = 13'($urandom_range(0, 3));
         clear_active_pulse = ($urandom_range(0, 3) == 0);
         clear_bank = 2'($urandom);
         #1;
         tests_run++; if (host_ready !== exp_ready()) begin tests_failed++; $display("FAIL rnd_ready[%0d] got %0b want %0b", n, host_ready, exp_ready()); end
         tick();
         tests_run++; if ({cmd_valid_r, cmd_write_r, new_bank, new_row, new_col} !== {m_rv, m_rw, 2'(m_rbank), 13'(m_rrow), 9'(m_rcol)}) begin
            tests_failed++; $display("FAIL rnd_r[%0d] got %h want %h", n, {cmd_valid_r, cmd_write_r, new_bank, new_row, new_col}, {m_rv, m_rw, 2'(m_rbank), 13'(m_rrow), 9'(m_rcol)}); end
         tests_run++; if ({cmd_write_q, cur_bank, cur_row, cur_col, cur_wdata} !== {m_qw, 2'(m_qbank), 13'(m_qrow), 9'(m_qcol), 16'(m_qdata)}) begin
            tests_failed++; $display("FAIL rnd_q[%0d] got %h want %h", n, {cmd_write_q, cur_bank, cur_row, cur_col, cur_wdata}, {m_qw, 2'(m_qbank), 13'(m_qrow), 9'(m_qcol), 16'(m_qdata)}); end
         tests_run++; if (row_hit !== exp_hit()) begin tests_failed++; $display("FAIL rnd_hit[%0d] got %0b want %0b", n, row_hit, exp_hit()); end
      end
      idle_inputs();
      drain();
   endtask

   task automatic test_reset_mid();
      set_active_pulse = 1; set_bank = 0; set_row = 13'd5;
      tick();
      idle_inputs();
      host_valid = 1; host_addr = mk_addr(5, 0, 7); host_wdata = 16'h1234;
      tick();
      tests_run++; if ({cmd_valid_r, row_hit} !== {1'b1, HIT_EN}) begin tests_failed++; $display("FAIL mid_pre got %b want %b", {cmd_valid_r, row_hit}, {1'b1, HIT_EN}); end
      accept_q_pulse = 1;
      tick();
      accept_q_pulse = 0;
      #2 rst_n = 0;
      model_reset();
      #1;
      tests_run++; if ({cmd_valid_r, row_hit} !== 2'b00) begin tests_failed++; $display("FAIL mid_reset got %b want 00", {cmd_valid_r, row_hit}); end
      tests_run++; if ({new_row, new_col, cur_row, cur_col, cur_wdata} !== '0) begin
         tests_failed++; $display("FAIL mid_fields got %h want 0", {new_row, new_col, cur_row, cur_col, cur_wdata}); end
      @(posedge clk); #1;
      tests_run++; if (cmd_valid_r !== 1'b0) begin tests_failed++; $display("FAIL mid_no_fire got %0b want 0", cmd_valid_r); end
      host_valid = 0;
      #1 rst_n = 1;
      host_valid = 1;
      tick();
      host_valid = 0;
      tests_run++; if ({cmd_valid_r, new_row, row_hit} !== {1'b1, 13'd5, 1'b0}) begin
         tests_failed++; $display("FAIL mid_table_cleared got %h want %h", {cmd_valid_r, new_row, row_hit}, {1'b1, 13'd5, 1'b0}); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_decode();
      test_back_to_back();
      test_row_hit();
      test_collision();
      test_init();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sdram_cmd_pipe.md
# sdram_cmd_pipe

Host-side command front end of the SDRAM controller, directly upstream of the controller FSM. Accepts host read/write requests over a valid/ready handshake and decodes the address into bank/row/column. Holds the request in stage R, which the FSM inspects, and copies it to stage Q when the FSM accepts it. Maintains the per-bank open-row table and produces the combinational `row_hit` that the FSM uses to choose between ACTIVE and a direct READ/WRITE.

## Interface

Parameters:
- ROW_BITS, 13, row address width
- COL_BITS, 9, column address width
- BANK_BITS, 2, bank address width
- DATA_BITS, 16, write data width
- ADDR_BITS, ROW_BITS+BANK_BITS+COL_BITS, host address width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- host_valid  in  1  host request valid
- host_ready  out  1  request accepted when valid & ready
- host_write  in  1  1 = write, 0 = read
- host_addr  in  ADDR_BITS  byte-free word address
- host_wdata  in  DATA_BITS  write data
- in_init  in  1  FSM in init sequence
- accept_q_pulse  in  1  FSM takes stage R into stage Q this cycle
- set_active_pulse / set_bank / set_row  in  1/BANK/ROW  mark bank open with row
- clear_active_pulse / clear_bank  in  1/BANK  mark bank closed
- cmd_valid_r, cmd_write_r  out  1  stage R valid and direction
- new_bank, new_col, new_row  out  BANK/COL/ROW  stage R decoded fields
- cmd_write_q, cur_bank, cur_col, cur_row, cur_wdata  out  stage Q fields
- row_hit  out  1  stage R targets the currently open row of its bank

## Operation

- Address map: host_addr = {row, bank, col}, i.e. col = addr[COL_BITS-1:0], bank = next BANK_BITS bits, row = top ROW_BITS bits.
- Stage R: single register plus valid flag r_valid (= cmd_valid_r).
  - host_ready = !in_init && (!r_valid || accept_q_pulse), combinational.
  - On host fire, R loads {write, bank, col, row, wdata} and r_valid is set.
  - On accept_q_pulse without a new fire, r_valid clears.
  - Fire and accept in the same cycle: R reloads and r_valid stays 1.
- Stage Q: on accept_q_pulse with r_valid=1, Q loads all R fields. Q holds its value otherwise; no valid flag, because the FSM owns its lifetime.
- accept_q_pulse with r_valid=0: ignored; neither R nor Q changes.
- Open-row table: open_v[bank] and open_row[bank] for 2^BANK_BITS banks.
  - clear_active_pulse clears open_v[clear_bank].
  - set_active_pulse sets open_v[set_bank] and writes open_row.
  - Set and clear on the same bank in the same cycle: set wins. On different banks, both apply.
  - in_init=1 clears every open_v each cycle, and overrides set.
- row_hit = r_valid && open_v[new_bank] && open_row[new_bank]==new_row. Combinational from registers only, with no path from host inputs.

## Timing

- Reset: r_valid, all R/Q fields, open_v and open_row are 0. Outputs are therefore 0, and row_hit=0.
- host_ready is 1 after reset only when in_init=0.
- Latency: host fire at edge N → cmd_valid_r/new_* valid after N, row_hit valid in the same cycle.
- accept_q_pulse at edge M → cur_* valid after M.
- Throughput: one request per cycle into R while the FSM accepts every cycle.
- Table update at edge K is visible to row_hit in cycle K+1.
- Async reset mid-request drops R and Q contents. No host handshake completes in the reset cycle.

## Configuration

- SDRAM_ROW_HIT_EN defined: open-row table built; row_hit as above.
- Undefined: no table registers; row_hit tied 0; set/clear inputs ignored (closed-page only). R/Q behaviour is identical in both builds.

## Structure

- Shared package sdram_pkg: ROW_BITS/COL_BITS/BANK_BITS/DATA_BITS defaults, the address-split function, and a cmd record typedef {write, bank, row, col, wdata} used for R and Q.
- One sub-module: sdram_open_row_table (set/clear/init-clear, lookup port bank+row → hit), instantiated only under SDRAM_ROW_HIT_EN.

## Test plan

- Decode: write addr 0x123456, wdata 0xBEEF → after 1 edge: cmd_valid_r=1, new_row=0x246, new_bank=2, new_col=0x056, cmd_write_r=1; host_ready=0 until accept.
- Accept + back-to-back: hold accept_q_pulse every cycle with 3 consecutive host requests → host_ready stays 1, and cur_* tracks each request one cycle after it appears in R.
- Row hit: set_active_pulse bank 2 row 0x246, then read 0x123400 → row_hit=1; read 0x1A3400 (row 0x346) → row_hit=0.
- Clear vs set collision: set and clear on bank 1 in the same cycle → open_v[1]=1. Then clear only → next R to bank 1 gives row_hit=0.
- Init: in_init=1 with host_valid=1 → host_ready=0 and all open_v cleared. After in_init falls, the request is taken next cycle.
- Reset mid-operation: assert rst_n=0 with r_valid=1 and bank 0 open → cmd_valid_r=0 and row_hit=0 immediately. Build without SDRAM_ROW_HIT_EN → row_hit=0 in every scenario above.
